// File: rtl/l2_miss_queue.sv
// L2 miss-status queue: in-order circular buffer of line misses/writebacks that issues
// to memory with bounded concurrency, collapses duplicate fills, and restarts in order.
module l2_miss_queue #(
    parameter int NUM_ENTRIES     = 8,
    parameter int MAX_OUTSTANDING = 4,
    parameter int ADDR_WIDTH      = 26,
    parameter int ID_WIDTH        = 6
) (
    input  logic                               clk_i,
    input  logic                               reset_i,
    input  logic                               enq_valid_i,
    output logic                               enq_ready_o,
    input  logic [ADDR_WIDTH-1:0]              enq_addr_i,
    input  logic                               enq_is_writeback_i,
    input  logic [ID_WIDTH-1:0]                enq_id_i,
    output logic                               enq_duplicate_o,
    output logic                               mem_req_valid_o,
    input  logic                               mem_req_ready_i,
    output logic [ADDR_WIDTH-1:0]              mem_req_addr_o,
    output logic                               mem_req_is_writeback_o,
    input  logic                               mem_rsp_valid_i,
    output logic                               mem_rsp_ready_o,
    output logic                               restart_valid_o,
    input  logic                               restart_ready_i,
    output logic [ADDR_WIDTH-1:0]              restart_addr_o,
    output logic [ID_WIDTH-1:0]                restart_id_o,
    output logic                               restart_is_writeback_o,
    output logic                               restart_duplicate_o,
    output logic [$clog2(NUM_ENTRIES):0]       occupancy_o,
    output logic [$clog2(MAX_OUTSTANDING):0]   outstanding_o
);

    localparam int PW = $clog2(NUM_ENTRIES);
    localparam int CW = PW + 1;
    localparam int OW = $clog2(MAX_OUTSTANDING) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(NUM_ENTRIES);
    localparam logic [OW-1:0] MAX_OUT  = OW'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        ST_FREE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_ISSUED  = 2'd2,
        ST_DONE    = 2'd3
    } ent_state_e;

    ent_state_e            state_q [NUM_ENTRIES];
    ent_state_e            state_d [NUM_ENTRIES];
    logic [ADDR_WIDTH-1:0] addr_q  [NUM_ENTRIES];
    logic [ADDR_WIDTH-1:0] addr_d  [NUM_ENTRIES];
    logic [ID_WIDTH-1:0]   id_q    [NUM_ENTRIES];
    logic [ID_WIDTH-1:0]   id_d    [NUM_ENTRIES];
    logic                  wb_q    [NUM_ENTRIES];
    logic                  wb_d    [NUM_ENTRIES];
    logic                  dup_q   [NUM_ENTRIES];
    logic                  dup_d   [NUM_ENTRIES];

    logic [PW-1:0] tail_q, tail_d, issue_q, issue_d, cmpl_q, cmpl_d, head_q, head_d;
    logic [CW-1:0] occ_q, occ_d;
    logic [OW-1:0] outs_q, outs_d;

    logic match_s, enq_fire_s, iss_pend_s, iss_dup_s, mem_issue_s, issue_fire_s;
    logic cmp_iss_s, cmpl_auto_s, mem_cmpl_s, cmpl_fire_s, retire_s;

    // Duplicate-fill detection: any live fill entry (including one retiring now) with the same line.
    always_comb begin
        match_s = 1'b0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            match_s = match_s | ((state_q[i] != ST_FREE) && !wb_q[i] && (addr_q[i] == enq_addr_i));
        end
        enq_duplicate_o = !enq_is_writeback_i && match_s;
    end

    // Handshake and pointer-target decode; all four stages look only at registered state.
    always_comb begin
        enq_ready_o            = (occ_q != FULL_CNT);
        enq_fire_s             = enq_valid_i && enq_ready_o;

        iss_pend_s             = (state_q[issue_q] == ST_PENDING);
        iss_dup_s              = iss_pend_s && dup_q[issue_q];
        mem_req_valid_o        = iss_pend_s && !dup_q[issue_q] && (outs_q < MAX_OUT);
        mem_req_addr_o         = addr_q[issue_q];
        mem_req_is_writeback_o = wb_q[issue_q];
        mem_issue_s            = mem_req_valid_o && mem_req_ready_i;
        issue_fire_s           = iss_dup_s || mem_issue_s;

        cmp_iss_s              = (state_q[cmpl_q] == ST_ISSUED);
        cmpl_auto_s            = cmp_iss_s && dup_q[cmpl_q];
        mem_rsp_ready_o        = cmp_iss_s && !dup_q[cmpl_q];
        mem_cmpl_s             = mem_rsp_ready_o && mem_rsp_valid_i;
        cmpl_fire_s            = cmpl_auto_s || mem_cmpl_s;

        restart_valid_o        = (state_q[head_q] == ST_DONE);
        restart_addr_o         = addr_q[head_q];
        restart_id_o           = id_q[head_q];
        restart_is_writeback_o = wb_q[head_q];
        restart_duplicate_o    = dup_q[head_q];
        retire_s               = restart_valid_o && restart_ready_i;
    end

    // Next-state: per-entry lifecycle, payload capture at tail, pointers and counters.
    always_comb begin
        state_d = state_q;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            case (state_q[i])
                ST_FREE:    state_d[i] = (enq_fire_s   && (tail_q  == PW'(i))) ? ST_PENDING : ST_FREE;
                ST_PENDING: state_d[i] = (issue_fire_s && (issue_q == PW'(i))) ? ST_ISSUED  : ST_PENDING;
                ST_ISSUED:  state_d[i] = (cmpl_fire_s  && (cmpl_q  == PW'(i))) ? ST_DONE    : ST_ISSUED;
                ST_DONE:    state_d[i] = (retire_s     && (head_q  == PW'(i))) ? ST_FREE    : ST_DONE;
                default:    state_d[i] = ST_FREE;
            endcase
        end

        addr_d         = addr_q;
        id_d           = id_q;
        wb_d           = wb_q;
        dup_d          = dup_q;
        addr_d[tail_q] = enq_fire_s ? enq_addr_i         : addr_q[tail_q];
        id_d[tail_q]   = enq_fire_s ? enq_id_i           : id_q[tail_q];
        wb_d[tail_q]   = enq_fire_s ? enq_is_writeback_i : wb_q[tail_q];
        dup_d[tail_q]  = enq_fire_s ? enq_duplicate_o    : dup_q[tail_q];

        tail_d  = tail_q  + PW'(enq_fire_s);
        issue_d = issue_q + PW'(issue_fire_s);
        cmpl_d  = cmpl_q  + PW'(cmpl_fire_s);
        head_d  = head_q  + PW'(retire_s);
        occ_d   = occ_q  + CW'(enq_fire_s)  - CW'(retire_s);
        outs_d  = outs_q + OW'(mem_issue_s) - OW'(mem_cmpl_s);
    end

    // State register; reset drops every entry and forgets in-flight transactions.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= '{default: ST_FREE};
            addr_q  <= '{default: '0};
            id_q    <= '{default: '0};
            wb_q    <= '{default: 1'b0};
            dup_q   <= '{default: 1'b0};
            tail_q  <= '0;
            issue_q <= '0;
            cmpl_q  <= '0;
            head_q  <= '0;
            occ_q   <= '0;
            outs_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            id_q    <= id_d;
            wb_q    <= wb_d;
            dup_q   <= dup_d;
            tail_q  <= tail_d;
            issue_q <= issue_d;
            cmpl_q  <= cmpl_d;
            head_q  <= head_d;
            occ_q   <= occ_d;
            outs_q  <= outs_d;
        end
    end

    assign occupancy_o   = occ_q;
    assign outstanding_o = outs_q;

    l2_miss_queue_checker #(
        .NUM_ENTRIES     (NUM_ENTRIES),
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) u_checker (
        .clk_i           (clk_i),
        .reset_i         (reset_i),
        .mem_rsp_valid_i (mem_rsp_valid_i),
        .mem_rsp_ready_i (mem_rsp_ready_o),
        .occupancy_i     (occ_q),
        .outstanding_i   (outs_q)
    );

endmodule

// Protocol and bound checks for the miss queue; a completion offered while not ready is ignored by the queue.
module l2_miss_queue_checker #(
    parameter int NUM_ENTRIES     = 8,
    parameter int MAX_OUTSTANDING = 4
) (
    input logic                             clk_i,
    input logic                             reset_i,
    input logic                             mem_rsp_valid_i,
    input logic                             mem_rsp_ready_i,
    input logic [$clog2(NUM_ENTRIES):0]     occupancy_i,
    input logic [$clog2(MAX_OUTSTANDING):0] outstanding_i
);

    localparam int CW = $clog2(NUM_ENTRIES) + 1;
    localparam int OW = $clog2(MAX_OUTSTANDING) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(NUM_ENTRIES);
    localparam logic [OW-1:0] MAX_OUT  = OW'(MAX_OUTSTANDING);

    a_rsp_protocol: assert property (@(posedge clk_i) disable iff (!reset_i)
        mem_rsp_valid_i |-> mem_rsp_ready_i);
    a_occ_bound: assert property (@(posedge clk_i) disable iff (!reset_i)
        occupancy_i <= FULL_CNT);
    a_out_bound: assert property (@(posedge clk_i) disable iff (!reset_i)
        outstanding_i <= MAX_OUT);

endmodule

// File: doc/l2_miss_queue.md
Name: l2_miss_queue

Overview:
- Parametrised L2 miss-status queue; the next-generation replacement for the single-transaction miss handling in the L2 system-memory path.
- Holds up to NUM_ENTRIES outstanding line misses/writebacks and issues them to the memory engine in order, with up to MAX_OUTSTANDING in flight.
- Collapses duplicate fills to the same line so that they never reach memory.
- Completed entries are handed back in allocation order for reissue into the L2 pipeline.

Parameters:
- NUM_ENTRIES, 8, queue depth; power of 2, >=2.
- MAX_OUTSTANDING, 4, maximum memory transactions issued but not completed; 1..NUM_ENTRIES.
- ADDR_WIDTH, 26, cache-line address width.
- ID_WIDTH, 6, opaque requester tag carried through the queue.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- enq_valid  in  1  new miss/writeback request.
- enq_ready  out  1  entry available.
- enq_addr  in  ADDR_WIDTH  line address.
- enq_is_writeback  in  1  1 = writeback, 0 = fill.
- enq_id  in  ID_WIDTH  requester tag.
- enq_duplicate  out  1  combinational; enq_addr matches a valid fill entry.
- mem_req_valid  out  1  memory transaction request.
- mem_req_ready  in  1  memory engine accepts.
- mem_req_addr  out  ADDR_WIDTH  address of the request.
- mem_req_is_writeback  out  1  kind of the request.
- mem_rsp_valid  in  1  oldest issued transaction finished (in-order).
- mem_rsp_ready  out  1  queue can take the completion.
- restart_valid  out  1  oldest entry done.
- restart_ready  in  1  pipeline takes restart.
- restart_addr  out  ADDR_WIDTH  address of the restart entry.
- restart_id  out  ID_WIDTH  tag of the restart entry.
- restart_is_writeback  out  1  kind of the restart entry.
- restart_duplicate  out  1  restart entry was collapsed.
- occupancy  out  $clog2(NUM_ENTRIES)+1  valid entry count.
- outstanding  out  $clog2(MAX_OUTSTANDING)+1  in-flight count.

Behaviour:
- Storage is a circular buffer with four pointers, each $clog2(NUM_ENTRIES) bits wide and wrapping naturally, all reset to 0:
  - tail: allocate.
  - issue: next to issue.
  - cmpl: oldest issued.
  - head: oldest.
- Per-entry state is one of FREE, PENDING, ISSUED, DONE; all entries are FREE at reset.
- Reset values: all counts 0; enq_ready=1; mem_req_valid=0; mem_rsp_ready=0; restart_valid=0.

Enqueue:
- Transfer occurs when enq_valid && enq_ready.
- enq_ready = (occupancy != NUM_ENTRIES), from registered state only. A retire in the same cycle does not free a slot for the enqueue.
- enq_duplicate = !enq_is_writeback && some non-FREE entry has is_writeback=0 and the same address. An entry retiring this cycle still counts as a match.
- On transfer, the entry at tail becomes PENDING and stores addr, id, is_writeback and dup=enq_duplicate; tail++.

Issue:
- The issue pointer targets a PENDING entry.
- If that entry has dup=1: it becomes ISSUED in one cycle without a memory request; mem_req_valid=0; the outstanding count is unchanged.
- If dup=0: mem_req_valid=1 when outstanding < MAX_OUTSTANDING. On mem_req_ready the entry becomes ISSUED, issue++ and outstanding++.
- mem_req_* are driven combinationally from the entry and must stay stable while valid && !ready.
- At most one entry advances per cycle.

Completion:
- If the entry at cmpl is ISSUED with dup=1: it becomes DONE automatically that cycle and cmpl++; mem_rsp_ready=0.
- If it is ISSUED with dup=0: mem_rsp_ready=1. On mem_rsp_valid the entry becomes DONE, cmpl++ and outstanding--.
- mem_rsp_valid while mem_rsp_ready=0 is a protocol error; flag it with an assertion and ignore it.

Retire:
- restart_valid = (entry at head is DONE).
- On restart_ready the entry becomes FREE and head++.
- restart_* hold stable while valid && !ready.

Simultaneous events:
- Enqueue, issue, completion and retire may all occur in the same cycle.
- occupancy += enq - retire; outstanding += issue - completion.
- Pointers advance independently.

Ordering and reset:
- FIFO ordering guarantees a duplicate restarts strictly after the original fill.
- Writebacks never set or match dup.
- Reset asserted mid-operation drops all entries immediately; in-flight memory transactions are forgotten.

Test Plan:
- Reset with enq_valid=1 held → enq_ready=1, all valids 0, occupancy=0. After release, one fill 0x100 id 3 is issued; mem_rsp completes it → restart_addr=0x100, restart_id=3, occupancy back to 0.
- Enqueue 8 fills without mem_req_ready → enq_ready=0 at occupancy=8; a 9th enq_valid is held. One retire alone frees a slot only on the following cycle.
- MAX_OUTSTANDING=4, 6 distinct fills, mem_req_ready=1, no responses → exactly 4 mem_req handshakes; outstanding=4; the 5th is issued only after one mem_rsp.
- Fill 0x200 id 1, then fill 0x200 id 2 → enq_duplicate=1 on the second and only one mem_req. Restarts come out id1 then id2, with restart_duplicate=0 then 1. A writeback to 0x200 gives enq_duplicate=0.
- Same cycle: enqueue + issue + mem_rsp + restart handshake → occupancy unchanged, outstanding unchanged, all four pointers advance. Run 20 entries to wrap the pointers and verify FIFO order.
- Reset asserted while outstanding=3 and occupancy=5 → same-cycle (asynchronous) clear of all counts and valids; a new enqueue after release behaves as from cold reset.
